// File: rtl/aes128_type_pkg.sv
// ---------------------------------------------------------------------------
// aes128_type_pkg
//
// Purpose:
//   Types, constants and helpers shared by the AES-128 round datapath
//   stages (SubBytes, ShiftRows, MixColumns, key schedule).
//
// Contents:
//   AES_STATE_BYTES  number of bytes in one AES state (16)
//   aes_state_t      packed 16-byte state, byte i at index i
//   shift_rows_idx   destination index of a state byte under ShiftRows or
//                    InvShiftRows
// ---------------------------------------------------------------------------
package aes128_type_pkg;

    localparam int AES_STATE_BYTES = 16;

    typedef logic [AES_STATE_BYTES-1:0][7:0] aes_state_t;

    // The state is column-major, so index = row + 4*col. Each row r rotates
    // by r positions. Left rotation moves a byte to column (c - r); right
    // rotation moves it to column (c + r). Two-bit column arithmetic gives
    // the mod-4 wrap for free.
    function automatic logic [3:0] shift_rows_idx(input logic [3:0] addr,
                                                  input logic       inverse);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] dest_col;
        row      = addr[1:0];
        col      = addr[3:2];
        dest_col = inverse ? (col + row) : (col - row);
        return {dest_col, row};
    endfunction

endpackage

// File: rtl/aes128_shift_rows.sv
// ---------------------------------------------------------------------------
// aes128_shift_rows
//
// Purpose:
//   ShiftRows stage of the AES-128 round datapath. It collects the serial
//   SubBytes stream into a 16-byte buffer, placing every byte directly at
//   its permuted position. Once all 16 positions have been written, it
//   streams the permuted state out in address order 0..15 and also
//   presents the whole buffer in parallel. INVERSE selects InvShiftRows
//   for the decrypt path.
//
// Parameters:
//   N_BYTES    bytes per state. Only 16 is supported.
//   INVERSE    0 = ShiftRows (rotate rows left), 1 = InvShiftRows (right)
//
// Ports:
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   data_i     substituted byte from upstream
//   addr_i     source state index of data_i (row + 4*col)
//   valid_i    data_i/addr_i valid this cycle
//   data_o     permuted state byte
//   addr_o     state index of data_o
//   valid_o    data_o/addr_o valid
//   done_o     pulse coincident with the last output byte
//   state_o    parallel permuted state, byte i at index i
//   overrun_o  pulse: valid_i arrived while streaming out, byte dropped
// ---------------------------------------------------------------------------
module aes128_shift_rows
    import aes128_type_pkg::*;
#(
    parameter int N_BYTES = AES_STATE_BYTES,
    parameter bit INVERSE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       data_i,
    input  logic [3:0]       addr_i,
    input  logic             valid_i,
    output logic [7:0]       data_o,
    output logic [3:0]       addr_o,
    output logic             valid_o,
    output logic             done_o,
    output aes_state_t       state_o,
    output logic             overrun_o
);

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

    localparam logic [N_BYTES-1:0] MASK_FULL = '1;
    localparam logic [3:0]         LAST_IDX  = 4'(N_BYTES - 1);

    state_e             state_q;
    logic [N_BYTES-1:0] mask_q;
    logic [3:0]         cnt_q;
    aes_state_t         buf_q;

    logic [3:0]         dest;
    logic [N_BYTES-1:0] mask_set;
    logic               in_output;

    // Destination slot of the incoming byte, plus the written mask as it
    // will look after this cycle's write. The full check uses the updated
    // mask so the final byte moves us to OUTPUT at the very edge that
    // stores it.
    always_comb begin
        dest     = shift_rows_idx(addr_i, INVERSE);
        mask_set = mask_q | (N_BYTES'(1) << dest);
    end

    // Collection and output sequencing. While collecting, bytes land at
    // their permuted slot; a repeated address simply overwrites its slot.
    // While streaming, input bytes are ignored and the counter walks the
    // buffer. The mask clears on the way back to COLLECT, so the next block
    // starts empty. The buffer itself is kept so that state_o holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (valid_i) begin
                        buf_q[dest] <= data_i;
                        mask_q      <= mask_set;
                        if (mask_set == MASK_FULL) begin
                            state_q <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_q   <= '0;
                        mask_q  <= '0;
                        state_q <= COLLECT;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    // Outputs are decoded from the registered state. Outside the output
    // phase the stream outputs are forced to zero. The parallel state is the
    // buffer register itself.
    always_comb begin
        in_output = (state_q == OUTPUT);
        valid_o   = in_output;
        addr_o    = in_output ? cnt_q : 4'd0;
        data_o    = in_output ? buf_q[cnt_q] : 8'd0;
        done_o    = in_output && (cnt_q == LAST_IDX);
        overrun_o = in_output && valid_i;
        state_o   = buf_q;
    end

endmodule
